// File: rtl/uart_rx.sv
// 8-bit UART receiver: start, 8 data bits LSB first, parity, stop.
// Presents each byte with a one-cycle valid strobe plus parity/framing error flags.
module uart_rx #(
    parameter int unsigned CLK_FREQ  = 50,
    parameter int unsigned UART_BPS  = 9600,
    parameter int unsigned CHECK_SEL = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       u_rx_i,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_parity_err_o,
    output logic       rx_frame_err_o,
    output logic       rx_busy_o
);

    localparam int unsigned BPS_DR   = CLK_FREQ * 1000000 / UART_BPS;
    localparam logic [15:0] CNT_LAST = 16'(BPS_DR - 1);
    localparam logic [15:0] CNT_MID  = 16'(BPS_DR / 2 - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, edge_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        perr_q, perr_d;
    logic        ferr_q, ferr_d;
    logic        fall, mid, bit_rx, exp_par;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            edge_q  <= 1'b1;
        end else begin
            sync1_q <= u_rx_i;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    // edge_q must have seen the line high, so a held-low line never re-arms
    assign fall    = edge_q & ~sync2_q;
    assign bit_rx  = sync2_q;
    assign mid     = (cnt_q == CNT_MID);
    assign exp_par = (CHECK_SEL != 0) ? ~(^shift_q) : (^shift_q);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + 16'd1;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        valid_d = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = S_START;
            end
            S_START: begin
                if (mid) begin
                    if (bit_rx) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        idx_d   = '0;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d[idx_q] = bit_rx;
                    if (idx_q == 3'd7) state_d = S_PARITY;
                    else               idx_d   = idx_q + 3'd1;
                end
            end
            S_PARITY: begin
                if (mid) begin
                    par_d   = bit_rx;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                // Leaving at mid-stop gives half a bit of slack for the next start edge
                if (mid) begin
                    state_d = S_IDLE;
                    data_d  = shift_q;
                    perr_d  = (par_q != exp_par);
                    ferr_d  = ~bit_rx;
                    valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rx_data_o       = data_q;
    assign rx_valid_o      = valid_q;
    assign rx_parity_err_o = perr_q;
    assign rx_frame_err_o  = ferr_q;
    assign rx_busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: one serial line feeds an odd-parity and an even-parity receiver;
// expected frames are queued at send time and popped by a monitor on each valid strobe.
module tb_uart_rx;

    localparam int unsigned BPS  = 10;
    localparam int unsigned HALF = BPS / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       u_rx;
    logic [7:0] o_data, e_data;
    logic       o_valid, o_perr, o_ferr, o_busy;
    logic       e_valid, e_perr, e_ferr, e_busy;

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [7:0]  d;
        logic        pe;
        logic        fe;
        int unsigned at;
    } exp_t;

    exp_t q_odd[$];
    exp_t q_even[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.CLK_FREQ(1), .UART_BPS(100000), .CHECK_SEL(1)) u_odd (
        .clk_i(clk), .rst_n_i(rst_n), .u_rx_i(u_rx),
        .rx_data_o(o_data), .rx_valid_o(o_valid), .rx_parity_err_o(o_perr),
        .rx_frame_err_o(o_ferr), .rx_busy_o(o_busy)
    );

    uart_rx #(.CLK_FREQ(1), .UART_BPS(100000), .CHECK_SEL(0)) u_even (
        .clk_i(clk), .rst_n_i(rst_n), .u_rx_i(u_rx),
        .rx_data_o(e_data), .rx_valid_o(e_valid), .rx_parity_err_o(e_perr),
        .rx_frame_err_o(e_ferr), .rx_busy_o(e_busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic cmp_frame(input string tag, input exp_t e, input logic [7:0] d,
                             input logic pe, input logic fe);
        chk({tag, "_data"}, {24'd0, d}, {24'd0, e.d});
        chk({tag, "_parity_err"}, {31'd0, pe}, {31'd0, e.pe});
        chk({tag, "_frame_err"}, {31'd0, fe}, {31'd0, e.fe});
        checks++;
        if (cyc + 1 < e.at || cyc > e.at + 1) begin
            errors++;
            $display("FAIL %s_valid_time: got cycle %0d expected %0d +-1", tag, cyc, e.at);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            if (q_odd.size() == 0) begin
                checks++; errors++;
                $display("FAIL odd_unexpected_valid: got strobe data %0h expected none at cycle %0d", o_data, cyc);
            end else begin
                cmp_frame("odd", q_odd.pop_front(), o_data, o_perr, o_ferr);
            end
        end
        if (e_valid === 1'b1) begin
            if (q_even.size() == 0) begin
                checks++; errors++;
                $display("FAIL even_unexpected_valid: got strobe data %0h expected none at cycle %0d", e_data, cyc);
            end else begin
                cmp_frame("even", q_even.pop_front(), e_data, e_perr, e_ferr);
            end
        end
    end

    // Reference: odd mode wants an odd count of ones over data+parity, even mode an even count
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] f;
        exp_t        eo, ee;
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 8; i++) ones += d[i];
        ones += par;
        eo.d  = d; eo.fe = ~stp; eo.at = cyc + 3 + HALF + 10 * BPS + 1;
        ee    = eo;
        eo.pe = (ones % 2 == 0);
        ee.pe = (ones % 2 == 1);
        q_odd.push_back(eo);
        q_even.push_back(ee);
        f = {stp, par, d, 1'b0};
        for (int unsigned k = 0; k < 11; k++) begin
            u_rx = f[k];
            step(BPS);
        end
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        int unsigned ones;
        ones = 0;
        for (int unsigned i = 0; i < 8; i++) ones += d[i];
        return (ones % 2 == 0);
    endfunction

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((q_odd.size() != 0 || q_even.size() != 0) && n < 400) begin
            step(1);
            n++;
        end
        checks++;
        if (q_odd.size() != 0 || q_even.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d frames outstanding expected 0", q_odd.size(), q_even.size());
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_odd_data"},  {24'd0, o_data}, 32'd0);
        chk({tag, "_odd_valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, "_odd_perr"},  {31'd0, o_perr}, 32'd0);
        chk({tag, "_odd_ferr"},  {31'd0, o_ferr}, 32'd0);
        chk({tag, "_odd_busy"},  {31'd0, o_busy}, 32'd0);
        chk({tag, "_even_data"}, {24'd0, e_data}, 32'd0);
        chk({tag, "_even_busy"}, {31'd0, e_busy}, 32'd0);
        chk({tag, "_even_ferr"}, {31'd0, e_ferr}, 32'd0);
    endtask

    initial begin
        logic [10:0] f;
        logic        saw_o, saw_e;
        logic [7:0]  d;
        logic        p, s;
        int unsigned gap;

        u_rx  = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst_n = 1'b1;
        step(5);

        send_frame(8'hA5, 1'b1, 1'b1);
        step(5);
        send_frame(8'h3C, 1'b0, 1'b1);
        step(5);

        // Frame error followed by a held-low break; only a fresh edge may re-arm
        send_frame(8'h81, odd_par(8'h81), 1'b0);
        step(30);
        u_rx = 1'b1;
        step(20);
        drain();
        send_frame(8'h5A, odd_par(8'h5A), 1'b1);
        step(5);

        u_rx = 1'b0;
        step(2);
        u_rx = 1'b1;
        saw_o = 1'b0;
        saw_e = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (o_busy) saw_o = 1'b1;
            if (e_busy) saw_e = 1'b1;
        end
        chk("glitch_odd_busy_seen",  {31'd0, saw_o}, 32'd1);
        chk("glitch_even_busy_seen", {31'd0, saw_e}, 32'd1);
        chk("glitch_odd_busy_clear", {31'd0, o_busy}, 32'd0);
        chk("glitch_even_busy_clear", {31'd0, e_busy}, 32'd0);
        step(5);

        send_frame(8'h00, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        step(5);
        drain();

        // Reset during data bit 4 of 0x55
        f = {1'b1, odd_par(8'h55), 8'h55, 1'b0};
        for (int unsigned k = 0; k < 5; k++) begin
            u_rx = f[k];
            step(BPS);
        end
        u_rx = f[5];
        step(HALF);
        rst_n = 1'b0;
        step(2);
        chk_reset("midreset");
        u_rx = 1'b1;
        step(2);
        rst_n = 1'b1;
        step(5);
        send_frame(8'h12, odd_par(8'h12), 1'b1);
        step(5);
        drain();

        for (int unsigned n = 0; n < 40; n++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) == 0) ? ~odd_par(d) : odd_par(d);
            s = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            send_frame(d, p, s);
            u_rx = 1'b1;
            gap = s ? $urandom_range(0, 3) : $urandom_range(3, 6);
            if (gap != 0) step(gap);
        end
        u_rx = 1'b1;
        step(5);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
